// File: rtl/ascon_block_packer_pkg.sv
// +----------------------------------------------------------------------------+
// | Module  : ascon_block_packer_pkg                                           |
// | Brief   : Shared types and constants for the ASCON byte-to-block packer.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package ascon_block_packer_pkg;

    // Packer sequencing states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_FULL = 3'd2,
        ST_PAD  = 3'd3,
        ST_DONE = 3'd4
    } type_packer_state;

    // Block made purely of padding (message length a multiple of 8 bytes)
    localparam logic [63:0] PAD_BLOCK = 64'h8000000000000000;

    // First padding byte of the ASCON 10* rule
    localparam logic [7:0]  PAD_BYTE  = 8'h80;

endpackage

`default_nettype wire

// File: rtl/ascon_block_packer_if.sv
// +----------------------------------------------------------------------------+
// | Module  : ascon_block_packer_if                                            |
// | Brief   : Byte-stream input, block output and counter bundle of the packer.|
// |           ovf_o exists only when ASCON_PACKER_OVF_EN is defined.           |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

interface ascon_block_packer_if #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 4
);
    logic              start_i;
    logic [7:0]        byte_i;
    logic              byte_valid_i;
    logic              byte_last_i;
    logic              byte_ready_o;
    logic [DATA_W-1:0] data_o;
    logic              data_valid_o;
    logic              data_last_o;
    logic              data_ack_i;
    logic [CNT_W-1:0]  counter_block_o;
`ifdef ASCON_PACKER_OVF_EN
    logic              ovf_o;

    // Side that feeds bytes and absorbs blocks
    modport master (
        output start_i, byte_i, byte_valid_i, byte_last_i, data_ack_i,
        input  byte_ready_o, data_o, data_valid_o, data_last_o, counter_block_o, ovf_o
    );

    // Packer side
    modport slave (
        input  start_i, byte_i, byte_valid_i, byte_last_i, data_ack_i,
        output byte_ready_o, data_o, data_valid_o, data_last_o, counter_block_o, ovf_o
    );
`else
    // Side that feeds bytes and absorbs blocks
    modport master (
        output start_i, byte_i, byte_valid_i, byte_last_i, data_ack_i,
        input  byte_ready_o, data_o, data_valid_o, data_last_o, counter_block_o
    );

    // Packer side
    modport slave (
        input  start_i, byte_i, byte_valid_i, byte_last_i, data_ack_i,
        output byte_ready_o, data_o, data_valid_o, data_last_o, counter_block_o
    );
`endif

endinterface

`default_nettype wire

// File: rtl/ascon_block_packer_pad_insert.sv
// +----------------------------------------------------------------------------+
// | Module  : ascon_block_packer_pad_insert                                    |
// | Brief   : Combinational 10* padding: keeps bytes above the index, puts    |
// |           0x80 at the index and zeros below. Index 8 passes word through. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module ascon_block_packer_pad_insert
    import ascon_block_packer_pkg::*;
(
    input  logic [63:0] word_in,
    input  logic [3:0]  idx,
    output logic [63:0] word_out
);

    // Byte j lives at [63-8j -: 8]; decide per byte lane
    always_comb begin
        word_out = '0;
        for (int j = 0; j < 8; j++) begin
            if (4'(j) < idx) begin
                word_out[63-8*j -: 8] = word_in[63-8*j -: 8];
            end else if (4'(j) == idx) begin
                word_out[63-8*j -: 8] = PAD_BYTE;
            end else begin
                word_out[63-8*j -: 8] = 8'h00;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ascon_block_packer.sv
// +----------------------------------------------------------------------------+
// | Module  : ascon_block_packer                                               |
// | Brief   : Packs a byte stream big-endian into 64-bit blocks, applies ASCON |
// |           10* padding and counts acknowledged blocks.                      |
// |           Optional: ASCON_PACKER_OVF_EN adds a saturating counter with a  |
// |           sticky ovf_o flag; otherwise the counter wraps.                 |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module ascon_block_packer
    import ascon_block_packer_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 4
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    ascon_block_packer_if.slave   bus
);

    type_packer_state  r_state;
    logic [DATA_W-1:0] r_data;
    logic [2:0]        r_idx;
    logic              r_last;
    logic              r_pad_pend;
    logic              r_valid;
    logic              r_ready;
    logic [CNT_W-1:0]  r_cnt;

    logic [63:0]       w_with_byte;
    logic [63:0]       w_pad_src;
    logic [3:0]        w_pad_idx;
    logic [63:0]       w_padded;
    logic              w_accept;
    logic              w_ack_take;

    assign w_accept   = bus.byte_valid_i & r_ready;
    assign w_ack_take = bus.data_ack_i & r_valid;

    // Current block with the incoming byte dropped into its lane
    always_comb begin
        w_with_byte = r_data;
        for (int j = 0; j < 8; j++) begin
            if (3'(j) == r_idx) begin
                w_with_byte[63-8*j -: 8] = bus.byte_i;
            end
        end
    end

    // A last data byte pads after itself; a bare end marker pads at the current slot
    always_comb begin
        if (bus.byte_valid_i) begin
            w_pad_src = w_with_byte;
            w_pad_idx = {1'b0, r_idx} + 4'd1;
        end else begin
            w_pad_src = r_data;
            w_pad_idx = {1'b0, r_idx};
        end
    end

    ascon_block_packer_pad_insert u_pad_insert (
        .word_in  (w_pad_src),
        .idx      (w_pad_idx),
        .word_out (w_padded)
    );

    // Sequencer: byte filling, block hand-off and padding block, registered outputs
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state    <= ST_IDLE;
            r_data     <= '0;
            r_idx      <= '0;
            r_last     <= 1'b0;
            r_pad_pend <= 1'b0;
            r_valid    <= 1'b0;
            r_ready    <= 1'b0;
        end else if (bus.start_i) begin
            r_state    <= ST_FILL;
            r_data     <= '0;
            r_idx      <= '0;
            r_last     <= 1'b0;
            r_pad_pend <= 1'b0;
            r_valid    <= 1'b0;
            r_ready    <= 1'b1;
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (w_accept) begin
                        if (r_idx == 3'd7) begin
                            // Full block; a last byte here still owes a padding block
                            r_data     <= w_with_byte;
                            r_idx      <= '0;
                            r_pad_pend <= bus.byte_last_i;
                            r_last     <= 1'b0;
                            r_state    <= ST_FULL;
                            r_valid    <= 1'b1;
                            r_ready    <= 1'b0;
                        end else if (bus.byte_last_i) begin
                            r_data  <= w_padded;
                            r_idx   <= '0;
                            r_last  <= 1'b1;
                            r_state <= ST_FULL;
                            r_valid <= 1'b1;
                            r_ready <= 1'b0;
                        end else begin
                            r_data <= w_with_byte;
                            r_idx  <= r_idx + 3'd1;
                        end
                    end else if (bus.byte_last_i && r_ready) begin
                        r_data  <= w_padded;
                        r_idx   <= '0;
                        r_last  <= 1'b1;
                        r_state <= ST_FULL;
                        r_valid <= 1'b1;
                        r_ready <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (w_ack_take) begin
                        if (r_pad_pend) begin
                            r_data     <= PAD_BLOCK;
                            r_last     <= 1'b1;
                            r_pad_pend <= 1'b0;
                            r_state    <= ST_PAD;
                        end else if (r_last) begin
                            r_data  <= '0;
                            r_last  <= 1'b0;
                            r_state <= ST_DONE;
                            r_valid <= 1'b0;
                        end else begin
                            r_data  <= '0;
                            r_state <= ST_FILL;
                            r_valid <= 1'b0;
                            r_ready <= 1'b1;
                        end
                    end
                end
                ST_PAD: begin
                    if (w_ack_take) begin
                        r_data  <= '0;
                        r_last  <= 1'b0;
                        r_state <= ST_DONE;
                        r_valid <= 1'b0;
                    end
                end
                ST_IDLE, ST_DONE: begin
                    r_valid <= 1'b0;
                    r_ready <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef ASCON_PACKER_OVF_EN
    logic r_ovf;

    // Block counter: saturates at all-ones and raises a sticky overflow flag
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (bus.start_i) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_ack_take) begin
            if (r_cnt == {CNT_W{1'b1}}) begin
                r_ovf <= 1'b1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.ovf_o = r_ovf;
`else
    // Block counter: wraps modulo 2^CNT_W
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_cnt <= '0;
        end else if (bus.start_i) begin
            r_cnt <= '0;
        end else if (w_ack_take) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
`endif

    assign bus.data_o          = r_data;
    assign bus.data_valid_o    = r_valid;
    assign bus.data_last_o     = r_last;
    assign bus.byte_ready_o    = r_ready;
    assign bus.counter_block_o = r_cnt;

endmodule

`default_nettype wire
